// File: rtl/exe_divider_pkg.sv
// Shared EXE-stage definitions: divider FSM encodings, step count
// and the exception cause codes used by the pipeline.
package exe_divider_pkg;

    localparam int DIV_STEPS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_STEPS) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/exe_divider_div_restore_step.sv
// One combinational restoring-division step: trial subtract of the
// divisor from the shifted partial remainder, keep it if no borrow.
module div_restore_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] prem_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W-1:0] diff;

    // Trial subtraction; restore the old value when it would go negative
    always_comb begin
        diff  = prem_i - dvs_i;
        q_o   = (prem_i >= dvs_i);
        rem_o = q_o ? diff : prem_i;
    end

endmodule

// File: rtl/exe_divider.sv
// Multi-cycle DIV/DIVU unit for the EXE stage: one restoring step per
// cycle on operand magnitudes, sign fix-up when the result is written.
module exe_divider
    import exe_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_start,
    input  logic             i_is_unsigned,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_STEPS - 1);

    div_state_e           state_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic                 valid_q;
    logic [WIDTH-1:0]     quo_out_q;
    logic [WIDTH-1:0]     rem_out_q;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH:0]       dvs_q;
    logic                 neg_q_q;
    logic                 neg_r_q;

    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a_d;
    logic [WIDTH:0]       mag_b_d;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       rem_d;
    logic                 qbit;
    logic [WIDTH-1:0]     quo_d;
    logic [WIDTH-1:0]     quo_fin_d;
    logic [WIDTH-1:0]     rem_fin_d;

    // Operand signs and magnitudes; the dividend magnitude of
    // 0x80000000 is still exact when read as an unsigned value
    always_comb begin
        sign_a  = ~i_is_unsigned & i_dividend[WIDTH-1];
        sign_b  = ~i_is_unsigned & i_divisor[WIDTH-1];
        mag_a_d = sign_a ? -i_dividend : i_dividend;
        mag_b_d = sign_b ? -{1'b1, i_divisor} : {1'b0, i_divisor};
    end

    // Shift the next dividend bit into the partial remainder
    always_comb begin
        shifted = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
    end

    div_restore_step #(
        .W(WIDTH + 1)
    ) u_step (
        .prem_i(shifted),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .q_o   (qbit)
    );

    // Quotient shift-in and final sign correction of both results
    always_comb begin
        quo_d     = {quo_q[WIDTH-2:0], qbit};
        quo_fin_d = neg_q_q ? -quo_d : quo_d;
        rem_fin_d = neg_r_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
    end

    // Control FSM with datapath registers and registered results
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (i_cancel) begin
                state_q <= DIV_IDLE;
            end else begin
                unique case (state_q)
                    DIV_IDLE: begin
                        if (i_start) begin
                            cnt_q   <= '0;
                            rem_q   <= '0;
                            quo_q   <= mag_a_d;
                            dvs_q   <= mag_b_d;
                            neg_q_q <= sign_a ^ sign_b;
                            neg_r_q <= sign_a;
                            if (i_divisor == '0) begin
                                state_q   <= DIV_DONE;
                                valid_q   <= 1'b1;
                                quo_out_q <= '1;
                                rem_out_q <= i_dividend;
                            end else begin
                                state_q <= DIV_CALC;
                            end
                        end
                    end
                    DIV_CALC: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + DIV_CNT_W'(1);
                        if (cnt_q == LAST_STEP) begin
                            state_q   <= DIV_DONE;
                            valid_q   <= 1'b1;
                            quo_out_q <= quo_fin_d;
                            rem_out_q <= rem_fin_d;
                        end
                    end
                    DIV_DONE: begin
                        state_q <= DIV_IDLE;
                    end
                    default: begin
                        state_q <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

    // Stall covers the start cycle; a flush suppresses the write strobe
    always_comb begin
        o_busy      = (state_q == DIV_CALC) |
                      ((state_q == DIV_IDLE) & i_start & ~i_cancel);
        o_valid     = valid_q & ~i_cancel;
        o_quotient  = quo_out_q;
        o_remainder = rem_out_q;
    end

endmodule

// File: tb/tb_exe_divider.sv
// Self-checking bench for exe_divider: scoreboard of expected
// quotient/remainder pairs plus per-scenario latency and stall checks.
module tb_exe_divider;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_start = 1'b0;
    logic        i_is_unsigned = 1'b0;
    logic [31:0] i_dividend = '0;
    logic [31:0] i_divisor = '0;
    logic        i_cancel = 1'b0;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;
    logic [63:0] last_exp = '0;

    exe_divider #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_start      (i_start),
        .i_is_unsigned(i_is_unsigned),
        .i_dividend   (i_dividend),
        .i_divisor    (i_divisor),
        .i_cancel     (i_cancel),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_quotient   (o_quotient),
        .o_remainder  (o_remainder)
    );

    always #5 clk = ~clk;

    // Scoreboard: every result strobe pops one expected pair
    always @(negedge clk) begin
        if (resetn && o_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid got q=%h r=%h required no strobe",
                         o_quotient, o_remainder);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_quotient, o_remainder} !== mon_e) begin
                    miscompares++;
                    $display("FAIL result got q=%h r=%h required q=%h r=%h",
                             o_quotient, o_remainder, mon_e[63:32], mon_e[31:0]);
                end
            end
        end
    end

    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input bit uns);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (uns) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'h8000_0000, 32'h0};
        return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
    endfunction

    // Present one start in cycle N; returns in cycle N+1 with start low
    task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                             input bit uns, input bit push,
                             input logic [63:0] ex, output bit busy0);
        @(negedge clk);
        i_dividend    = a;
        i_divisor     = b;
        i_is_unsigned = uns;
        i_start       = 1'b1;
        if (push) begin
            exp_q.push_back(ex);
            last_exp = ex;
        end
        #1 busy0 = o_busy;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Count cycles (from N+1) until the strobe; -1 if it never comes
    task automatic wait_valid(output int lat, output int busy_cyc,
                              output bit busy_at_valid);
        lat = -1;
        busy_cyc = 0;
        busy_at_valid = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (o_valid) begin
                lat = k;
                busy_at_valid = o_busy;
                break;
            end
            if (o_busy) busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        vectors++;
        if ({o_valid, o_busy, o_quotient, o_remainder} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_state got v=%b b=%b q=%h r=%h required all 0",
                     o_valid, o_busy, o_quotient, o_remainder);
        end
        i_start = 1'b1;
        #1;
        vectors++;
        if (o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy_follows_start got %b required 1", o_busy);
        end
        i_start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_unsigned();
        bit b0, bv;
        int lat, bc;
        start_div(32'd100, 32'd7, 1'b1, 1'b1, {32'd14, 32'd2}, b0);
        wait_valid(lat, bc, bv);
        vectors++;
        if ({b0, bv} !== 2'b10 || lat !== 33 || bc !== 32) begin
            miscompares++;
            $display("FAIL udiv_timing got busy0=%b lat=%0d busy=%0d bv=%b required 1 33 32 0",
                     b0, lat, bc, bv);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (o_valid !== 1'b0 || o_quotient !== 32'd14 || o_remainder !== 32'd2) begin
            miscompares++;
            $display("FAIL udiv_hold got v=%b q=%h r=%h required 0 e 2",
                     o_valid, o_quotient, o_remainder);
        end
    endtask

    task automatic test_signed();
        bit b0, bv;
        int lat, bc;
        start_div(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1,
                  {32'hFFFF_FFFD, 32'hFFFF_FFFF}, b0);
        wait_valid(lat, bc, bv);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("FAIL sdiv_latency got %0d required 33", lat);
        end
        start_div(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, {32'hFFFF_FFFD, 32'd1}, b0);
        wait_valid(lat, bc, bv);
        start_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1'b1,
                  {32'd3, 32'hFFFF_FFFF}, b0);
        wait_valid(lat, bc, bv);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("FAIL sdiv_negneg_latency got %0d required 33", lat);
        end
    endtask

    task automatic test_div_zero();
        bit b0, bv;
        int lat, bc;
        for (int u = 0; u < 2; u++) begin
            start_div(32'd5, 32'd0, u[0], 1'b1, {32'hFFFF_FFFF, 32'd5}, b0);
            wait_valid(lat, bc, bv);
            vectors++;
            if (lat !== 1 || b0 !== 1'b1 || bv !== 1'b0) begin
                miscompares++;
                $display("FAIL divzero_timing u=%0d got lat=%0d busy0=%b bv=%b required 1 1 0",
                         u, lat, b0, bv);
            end
        end
        start_div(32'h8000_0000, 32'd0, 1'b0, 1'b1,
                  {32'hFFFF_FFFF, 32'h8000_0000}, b0);
        wait_valid(lat, bc, bv);
    endtask

    task automatic test_overflow();
        bit b0, bv;
        int lat, bc;
        start_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1,
                  {32'h8000_0000, 32'd0}, b0);
        wait_valid(lat, bc, bv);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("FAIL ovf_latency got %0d required 33", lat);
        end
        start_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1,
                  {32'd0, 32'h8000_0000}, b0);
        wait_valid(lat, bc, bv);
    endtask

    task automatic test_cancel();
        bit b0, bv, seen;
        int lat, bc;
        logic [63:0] prev;
        prev = last_exp;
        start_div(32'd100, 32'd7, 1'b1, 1'b0, '0, b0);
        repeat (9) @(negedge clk);
        i_cancel = 1'b1;
        #1;
        vectors++;
        if (o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_no_strobe got %b required 0", o_valid);
        end
        @(negedge clk);
        i_cancel = 1'b0;
        #1;
        vectors++;
        if (o_busy !== 1'b0 || {o_quotient, o_remainder} !== prev) begin
            miscompares++;
            $display("FAIL cancel_idle got busy=%b q=%h r=%h required 0 q=%h r=%h",
                     o_busy, o_quotient, o_remainder, prev[63:32], prev[31:0]);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1 if (o_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_aborted got strobe=%b required 0", seen);
        end
        @(negedge clk);
        i_dividend = 32'd100;
        i_divisor  = 32'd7;
        i_start    = 1'b1;
        i_cancel   = 1'b1;
        #1;
        vectors++;
        if (o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_over_start got busy=%b required 0", o_busy);
        end
        @(negedge clk);
        i_start  = 1'b0;
        i_cancel = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1 if (o_valid || o_busy) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_start_ignored got activity=%b required 0", seen);
        end
        start_div(32'd9, 32'd3, 1'b1, 1'b1, {32'd3, 32'd0}, b0);
        wait_valid(lat, bc, bv);
        vectors++;
        if (lat !== 33) begin
            miscompares++;
            $display("FAIL after_cancel_latency got %0d required 33", lat);
        end
    endtask

    task automatic test_reset_mid();
        bit b0;
        start_div(32'd100, 32'd7, 1'b1, 1'b0, '0, b0);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if ({o_valid, o_busy, o_quotient, o_remainder} !== 66'd0) begin
            miscompares++;
            $display("FAIL async_reset got v=%b b=%b q=%h r=%h required all 0",
                     o_valid, o_busy, o_quotient, o_remainder);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_idle got b=%b v=%b required 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit b0, bv;
        int lat, bc;
        start_div(32'd8, 32'd2, 1'b1, 1'b1, {32'd4, 32'd0}, b0);
        wait_valid(lat, bc, bv);
        i_dividend = 32'd1;
        i_divisor  = 32'd0;
        i_start    = 1'b1;
        start_div(32'd9, 32'd4, 1'b1, 1'b1, {32'd2, 32'd1}, b0);
        wait_valid(lat, bc, bv);
        vectors++;
        if (lat !== 33 || b0 !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back got lat=%0d busy0=%b required 33 1", lat, b0);
        end
    endtask

    task automatic test_random();
        bit b0, bv, uns;
        int lat, bc;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a   = $urandom;
            b   = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            if (i % 3 == 1) b = -32'($urandom_range(1, 9));
            uns = 1'($urandom_range(0, 1));
            start_div(a, b, uns, 1'b1, model(a, b, uns), b0);
            wait_valid(lat, bc, bv);
            vectors++;
            if (lat !== (b == 0 ? 1 : 33)) begin
                miscompares++;
                $display("FAIL rand_latency a=%h b=%h got %0d", a, b, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
